// File: rtl/btn_pkg.sv
// Shared constants, event FSM state type and helper functions for the button conditioner.
package btn_pkg;

  localparam int NUM_BTN_MAX = 8;
  localparam int EVT_CODE_W  = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } evt_state_t;

  // Counter only has to reach DEBOUNCE_CYCLES-1, so ceil(log2) bits suffice.
  function automatic int cnt_width(input int debounce_cycles);
    return (debounce_cycles <= 2) ? 1 : $clog2(debounce_cycles);
  endfunction

  function automatic logic [EVT_CODE_W-1:0] lowest_index(input logic [NUM_BTN_MAX-1:0] vec);
    logic [EVT_CODE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_BTN_MAX - 1; i >= 0; i--) begin
      if (vec[i]) idx = EVT_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button lane: 2-flop synchronizer, stability counter, debounced level and edge pulses.
module debounce_cell
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             rise_reg;
  logic             fall_reg;

  logic mismatch;
  logic accept;

  // sync_reg[1] is the synchronized sample; nothing looks at sync_reg[0] or raw.
  assign mismatch = sync_reg[1] ^ level_reg;
  assign accept   = mismatch && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
      if (!mismatch || accept) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (accept) begin
        level_reg <= ~level_reg;
      end
      rise_reg <= accept & ~level_reg;
      fall_reg <= accept & level_reg;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces NUM_BTN raw buttons and turns press edges into a single-entry event
// with sticky overflow for presses that could not be queued.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_BTN-1:0]    btn_raw,
  output logic [NUM_BTN-1:0]    btn_level,
  output logic [NUM_BTN-1:0]    btn_rise,
  output logic [NUM_BTN-1:0]    btn_fall,
  output logic                  evt_valid,
  output logic [EVT_CODE_W-1:0] evt_code,
  input  logic                  evt_ack,
  output logic                  evt_overflow,
  input  logic                  ovf_clear
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_cell
      debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_raw[gi]),
        .level(btn_level[gi]),
        .rise (btn_rise[gi]),
        .fall (btn_fall[gi])
      );
    end
  endgenerate

  evt_state_t            state_reg;
  logic                  evt_valid_reg;
  logic [EVT_CODE_W-1:0] evt_code_reg;
  logic                  evt_overflow_reg;

  logic [NUM_BTN_MAX-1:0] rise_ext;
  logic                   any_rise;
  logic                   multi_rise;
  logic [EVT_CODE_W-1:0]  rise_code;
  logic                   can_accept;
  logic                   set_ovf;

  assign rise_ext   = NUM_BTN_MAX'(btn_rise);
  assign any_rise   = |rise_ext;
  assign multi_rise = |(rise_ext & (rise_ext - 1'b1));
  assign rise_code  = lowest_index(rise_ext);

  // When a slot is free (idle, or being acked) only the losers of the same-cycle
  // race overflow; otherwise every rise is dropped.
  assign can_accept = (state_reg == IDLE) || evt_ack;
  assign set_ovf    = can_accept ? multi_rise : any_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      evt_valid_reg    <= 1'b0;
      evt_code_reg     <= '0;
      evt_overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_rise) begin
            state_reg     <= PENDING;
            evt_valid_reg <= 1'b1;
            evt_code_reg  <= rise_code;
          end
        end
        PENDING: begin
          if (evt_ack) begin
            if (any_rise) begin
              evt_code_reg <= rise_code;
            end else begin
              state_reg     <= IDLE;
              evt_valid_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          evt_valid_reg <= 1'b0;
        end
      endcase

      if (set_ovf) begin
        evt_overflow_reg <= 1'b1;
      end else if (ovf_clear) begin
        evt_overflow_reg <= 1'b0;
      end
    end
  end

  assign evt_valid    = evt_valid_reg;
  assign evt_code     = evt_code_reg;
  assign evt_overflow = evt_overflow_reg;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed test of btn_conditioner with DEBOUNCE_CYCLES=4 (raw edge to level = 6 cycles).
module tb_btn_conditioner;

  localparam int NB = 8;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_rise;
  logic [NB-1:0] btn_fall;
  logic          evt_valid;
  logic [2:0]    evt_code;
  logic          evt_ack;
  logic          evt_overflow;
  logic          ovf_clear;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_rise    (btn_rise),
    .btn_fall    (btn_fall),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .evt_ack     (evt_ack),
    .evt_overflow(evt_overflow),
    .ovf_clear   (ovf_clear)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, 32'(btn_level), 32'h0);
    check({tag, "_rise"},  32'(btn_rise),  32'h0);
    check({tag, "_fall"},  32'(btn_fall),  32'h0);
    check({tag, "_valid"}, 32'(evt_valid), 32'h0);
    check({tag, "_code"},  32'(evt_code),  32'h0);
    check({tag, "_ovf"},   32'(evt_overflow), 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    btn_raw   = '0;
    evt_ack   = 1'b0;
    ovf_clear = 1'b0;
    step(2);
    check_all_zero("reset");
    rst = 1'b0;
    step(2);

    // Glitch of 3 raw cycles must not reach btn_level.
    btn_raw[0] = 1'b1;
    step(3);
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("glitch_level", 32'(btn_level), 32'h0);
      check("glitch_rise",  32'(btn_rise),  32'h0);
    end
    check("glitch_valid", 32'(evt_valid), 32'h0);
    $display("txn glitch btn0: level=%0h valid=%0b", btn_level, evt_valid);

    // Clean press on button 2: level at cycle 6, event the cycle after.
    btn_raw[2] = 1'b1;
    step(5);
    check("press2_early_level", 32'(btn_level), 32'h0);
    step(1);
    check("press2_level", 32'(btn_level), 32'h04);
    check("press2_rise",  32'(btn_rise),  32'h04);
    step(1);
    check("press2_rise_one_cycle", 32'(btn_rise), 32'h0);
    check("press2_valid", 32'(evt_valid), 32'h1);
    check("press2_code",  32'(evt_code),  32'h2);
    check("press2_ovf",   32'(evt_overflow), 32'h0);
    $display("txn press btn2: valid=%0b code=%0d", evt_valid, evt_code);

    evt_ack = 1'b1;
    step(1);
    check("ack_to_idle", 32'(evt_valid), 32'h0);
    step(1);
    evt_ack = 1'b0;
    check("ack_in_idle", 32'(evt_valid), 32'h0);
    $display("txn ack: valid=%0b", evt_valid);

    // Simultaneous rises on 5 and 1: lowest wins, the other overflows.
    btn_raw[5] = 1'b1;
    btn_raw[1] = 1'b1;
    step(6);
    check("dual_rise", 32'(btn_rise), 32'h22);
    step(1);
    check("dual_valid", 32'(evt_valid), 32'h1);
    check("dual_code",  32'(evt_code),  32'h1);
    check("dual_ovf",   32'(evt_overflow), 32'h1);
    ovf_clear = 1'b1;
    step(1);
    ovf_clear = 1'b0;
    check("dual_ovf_clear", 32'(evt_overflow), 32'h0);
    check("dual_code_hold", 32'(evt_code), 32'h1);
    $display("txn dual press 5+1: code=%0d ovf cleared=%0b", evt_code, evt_overflow);

    // Rise on 3 while pending without ack is dropped.
    btn_raw[3] = 1'b1;
    step(7);
    check("drop_valid", 32'(evt_valid), 32'h1);
    check("drop_code",  32'(evt_code),  32'h1);
    check("drop_ovf",   32'(evt_overflow), 32'h1);
    ovf_clear = 1'b1;
    step(1);
    ovf_clear = 1'b0;
    check("drop_ovf_clear", 32'(evt_overflow), 32'h0);
    $display("txn drop btn3: code=%0d ovf=%0b", evt_code, evt_overflow);

    // Ack coincides with button 4 rise: back-to-back event, no bubble.
    btn_raw[4] = 1'b1;
    step(6);
    check("b2b_rise", 32'(btn_rise), 32'h10);
    evt_ack = 1'b1;
    step(1);
    evt_ack = 1'b0;
    check("b2b_valid", 32'(evt_valid), 32'h1);
    check("b2b_code",  32'(evt_code),  32'h4);
    check("b2b_ovf",   32'(evt_overflow), 32'h0);
    evt_ack = 1'b1;
    step(1);
    evt_ack = 1'b0;
    check("b2b_ack_idle", 32'(evt_valid), 32'h0);
    $display("txn back-to-back btn4: code=%0d", evt_code);

    // Release of button 4: fall pulse, no event.
    btn_raw[4] = 1'b0;
    step(6);
    check("fall_pulse", 32'(btn_fall), 32'h10);
    check("fall_level", 32'(btn_level), 32'h2E);
    step(1);
    check("fall_one_cycle", 32'(btn_fall), 32'h0);
    check("fall_no_event", 32'(evt_valid), 32'h0);
    $display("txn release btn4: level=%0h valid=%0b", btn_level, evt_valid);

    // Overflow set and clear in the same cycle: set wins.
    btn_raw[6] = 1'b1;
    step(7);
    check("p6_code", 32'(evt_code), 32'h6);
    btn_raw[7] = 1'b1;
    step(6);
    ovf_clear = 1'b1;
    step(1);
    ovf_clear = 1'b0;
    check("set_wins_ovf", 32'(evt_overflow), 32'h1);
    ovf_clear = 1'b1;
    step(1);
    ovf_clear = 1'b0;
    check("set_wins_clear_after", 32'(evt_overflow), 32'h0);
    $display("txn set-vs-clear: code=%0d ovf=%0b", evt_code, evt_overflow);

    // Reset while pending and with button 0 mid-count.
    btn_raw[0] = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    check_all_zero("midrst");
    step(1);
    rst = 1'b0;
    step(5);
    check("post_rst_early_level", 32'(btn_level), 32'h0);
    check("post_rst_no_stale", 32'(evt_valid), 32'h0);
    step(1);
    check("post_rst_level", 32'(btn_level), 32'hEF);
    check("post_rst_rise",  32'(btn_rise),  32'hEF);
    step(1);
    check("post_rst_rise_once", 32'(btn_rise), 32'h0);
    check("post_rst_valid", 32'(evt_valid), 32'h1);
    check("post_rst_code",  32'(evt_code),  32'h0);
    check("post_rst_ovf",   32'(evt_overflow), 32'h1);
    $display("txn reset-held buttons: level=%0h code=%0d ovf=%0b", btn_level, evt_code, evt_overflow);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter NUM_BTN, default 8: number of raw button inputs; range 2..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples needed to accept a new level; range 2..255.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port btn_raw  input  NUM_BTN: asynchronous button/switch levels, active-high, bounce-prone.
REQ-006 Port btn_level  output  NUM_BTN: debounced level per button.
REQ-007 Port btn_rise  output  NUM_BTN: one-cycle pulse per button when its debounced level goes 0->1.
REQ-008 Port btn_fall  output  NUM_BTN: one-cycle pulse per button when its debounced level goes 1->0.
REQ-009 Port evt_valid  output  1: a press event is pending.
REQ-010 Port evt_code  output  3: index of the pending pressed button; valid only while evt_valid=1.
REQ-011 Port evt_ack  input  1: consumer accepts the pending event.
REQ-012 Port evt_overflow  output  1: sticky flag; at least one press was dropped while an event was pending.
REQ-013 Port ovf_clear  input  1: clears evt_overflow.

Function
REQ-014 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Per-button debounce counter SHALL reset to 0 whenever the synchronized sample equals btn_level, and SHALL otherwise increment.
REQ-016 When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, btn_level SHALL toggle on that edge and the counter SHALL return to 0.
REQ-017 Latency from a clean raw edge to btn_level change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL NOT change btn_level.
REQ-019 btn_rise/btn_fall SHALL assert in the same cycle btn_level changes, for exactly one cycle.
REQ-020 Event FSM states: IDLE (evt_valid=0) and PENDING (evt_valid=1).
REQ-021 IDLE with any btn_rise bit set: go to PENDING; latch evt_code = lowest set index.
REQ-022 IDLE with multiple simultaneous rises: lowest index wins; the others SHALL set evt_overflow.
REQ-023 PENDING: evt_code SHALL hold stable until ack.
REQ-024 PENDING with evt_ack=1 and no rise: go to IDLE.
REQ-025 PENDING with evt_ack=1 and a rise in the same cycle: stay in PENDING with the new lowest-index code (back-to-back, no bubble); extra rises set overflow.
REQ-026 PENDING with no ack and any rise: the rise is dropped and evt_overflow SHALL be set.
REQ-027 evt_ack in IDLE SHALL be ignored.
REQ-028 ovf_clear and a new overflow condition in the same cycle: set wins, so evt_overflow stays 1.
REQ-029 btn_fall SHALL never generate an event.

Reset
REQ-030 While rst=1: synchronizers, counters, btn_level, btn_rise, btn_fall, evt_valid, evt_code and evt_overflow SHALL all be 0, and the FSM SHALL be in IDLE.
REQ-031 Reset asserted mid-debounce or in PENDING SHALL discard all state; the first cycle after release behaves as power-up.
REQ-032 A button held high through reset release SHALL produce exactly one btn_rise and one event after 2 + DEBOUNCE_CYCLES cycles.

Structure
REQ-033 Package btn_pkg SHALL hold NUM_BTN_MAX=8, EVT_CODE_W=3, the FSM state typedef {IDLE, PENDING}, and a function computing counter width from DEBOUNCE_CYCLES.
REQ-034 Sub-module debounce_cell (one synchronizer plus counter plus level plus edge pulse) SHALL be instantiated NUM_BTN times; the FSM SHALL live in the top level.

Verification
REQ-035 DEBOUNCE_CYCLES=4: btn_raw[2] 0->1 held -> btn_level[2]=1 and btn_rise[2] pulse at cycle 6; evt_valid=1, evt_code=2.
REQ-036 btn_raw[0] high for 3 cycles, then low -> btn_level[0] stays 0; no rise, no event.
REQ-037 Rises on buttons 5 and 1 in the same cycle -> evt_code=1, evt_overflow=1.
REQ-038 Event pending with no ack, then button 3 rises -> evt_code unchanged, evt_overflow=1; ovf_clear -> 0 next cycle.
REQ-039 Ack in the same cycle as a button 4 rise -> evt_valid stays 1, evt_code=4 on the next cycle.
REQ-040 rst pulsed while in PENDING with counters mid-count -> all outputs 0 the next cycle, and no stale event after release.
